// File: rtl/vga_text_renderer_if.sv
// Bundles the renderer's pixel-side signals: timing-generator inputs, char RAM / font ROM ports, DAC outputs.
// master = surrounding system (timing generator, memories, board); slave = the renderer.
interface vga_text_renderer_if;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank;
    logic [11:0] CounterX;
    logic [11:0] CounterY;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        out_hs;
    logic        out_vs;
    logic        out_blank;
    logic [3:0]  out_r;
    logic [3:0]  out_g;
    logic [3:0]  out_b;
    logic [7:0]  frame_cnt;

    modport master (
        output vga_hs, vga_vs, vga_blank, CounterX, CounterY,
        output char_data, font_data, cursor_col, cursor_row,
        input  char_addr, font_addr,
        input  out_hs, out_vs, out_blank, out_r, out_g, out_b, frame_cnt
    );

    modport slave (
        input  vga_hs, vga_vs, vga_blank, CounterX, CounterY,
        input  char_data, font_data, cursor_col, cursor_row,
        output char_addr, font_addr,
        output out_hs, out_vs, out_blank, out_r, out_g, out_b, frame_cnt
    );
endinterface

// File: rtl/vga_text_renderer.sv
// Monochrome 8x16-cell text renderer between the VGA timing generator and the DAC pins.
// Latency: fixed 5 pixel clocks, sync/blank delayed to match; no backpressure (pixel-rate stream).
// Optional cursor blink when CURSOR_BLINK_EN is defined.
module vga_text_renderer #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 30,
    parameter logic [11:0] FG_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB = 12'h000
) (
    input logic           pixel_clk,
    input logic           reset,
    vga_text_renderer_if.slave vif
);
    localparam logic [11:0] TEXT_W = 12'(COLS * 8);
    localparam logic [11:0] TEXT_H = 12'(ROWS * 16);
    localparam logic [11:0] COLS12 = 12'(COLS);

    logic [11:0]      char_addr_q, char_addr_d;
    logic [11:0]      font_addr_q, font_addr_d;
    logic [4:0]       hs_sr_q, hs_sr_d;
    logic [4:0]       vs_sr_q, vs_sr_d;
    logic [4:0]       blank_sr_q, blank_sr_d;
    logic [3:0]       in_text_sr_q, in_text_sr_d;
    logic [1:0][3:0]  ylo_sr_q, ylo_sr_d;
    logic [3:0][2:0]  x3_sr_q, x3_sr_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             vs_prev_q, vs_prev_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             in_text;
    logic             pix_bit;

`ifdef CURSOR_BLINK_EN
    logic [8:0] col_q, col_d;
    logic [7:0] row_q, row_d;
    logic [2:0] cur_sr_q, cur_sr_d;
    logic       cur_match;
`else
    logic       unused_cursor;
    assign unused_cursor = ^{vif.cursor_col, vif.cursor_row};
`endif

    always_comb begin
        in_text      = (vif.CounterX < TEXT_W) && (vif.CounterY < TEXT_H);
        char_addr_d  = char_addr_q;
        if (in_text) begin
            char_addr_d = ({4'b0, vif.CounterY[11:4]} * COLS12) + {3'b0, vif.CounterX[11:3]};
        end
        in_text_sr_d = {in_text_sr_q[2:0], in_text};
        ylo_sr_d     = {ylo_sr_q[0], vif.CounterY[3:0]};
        x3_sr_d      = {x3_sr_q[2:0], vif.CounterX[2:0]};
        font_addr_d  = {vif.char_data, ylo_sr_q[1]};
        hs_sr_d      = {hs_sr_q[3:0], vif.vga_hs};
        vs_sr_d      = {vs_sr_q[3:0], vif.vga_vs};
        blank_sr_d   = {blank_sr_q[3:0], vif.vga_blank};

        // font_data bit7 is the leftmost pixel, so index with 7-x3 (= ~x3)
        pix_bit = vif.font_data[~x3_sr_q[3]];
`ifdef CURSOR_BLINK_EN
        col_d     = vif.CounterX[11:3];
        row_d     = vif.CounterY[11:4];
        cur_match = (int'(vif.cursor_col) < COLS) && (int'(vif.cursor_row) < ROWS) &&
                    (col_q == {2'b0, vif.cursor_col}) && (row_q == {3'b0, vif.cursor_row});
        cur_sr_d  = {cur_sr_q[1:0], cur_match};
        pix_bit   = pix_bit ^ (cur_sr_q[2] & frame_cnt_q[5]);
`endif

        rgb_d = 12'h000;
        if (blank_sr_q[3] && in_text_sr_q[3]) begin
            rgb_d = pix_bit ? FG_RGB : BG_RGB;
        end

        // frame_cnt counts falling edges of vsync (start of the pulse)
        vs_prev_d   = vif.vga_vs;
        frame_cnt_d = frame_cnt_q;
        if (vs_prev_q && !vif.vga_vs) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            char_addr_q  <= '0;
            font_addr_q  <= '0;
            hs_sr_q      <= '1;
            vs_sr_q      <= '1;
            blank_sr_q   <= '0;
            in_text_sr_q <= '0;
            ylo_sr_q     <= '0;
            x3_sr_q      <= '0;
            rgb_q        <= '0;
            vs_prev_q    <= 1'b1;
            frame_cnt_q  <= '0;
        end else begin
            char_addr_q  <= char_addr_d;
            font_addr_q  <= font_addr_d;
            hs_sr_q      <= hs_sr_d;
            vs_sr_q      <= vs_sr_d;
            blank_sr_q   <= blank_sr_d;
            in_text_sr_q <= in_text_sr_d;
            ylo_sr_q     <= ylo_sr_d;
            x3_sr_q      <= x3_sr_d;
            rgb_q        <= rgb_d;
            vs_prev_q    <= vs_prev_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef CURSOR_BLINK_EN
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            col_q    <= '0;
            row_q    <= '0;
            cur_sr_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            cur_sr_q <= cur_sr_d;
        end
    end
`endif

    assign vif.char_addr = char_addr_q;
    assign vif.font_addr = font_addr_q;
    assign vif.out_hs    = hs_sr_q[4];
    assign vif.out_vs    = vs_sr_q[4];
    assign vif.out_blank = blank_sr_q[4];
    assign vif.out_r     = rgb_q[11:8];
    assign vif.out_g     = rgb_q[7:4];
    assign vif.out_b     = rgb_q[3:0];
    assign vif.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: char RAM / font ROM models, scoreboard of {hs,vs,blank,rgb} checked 5 cycles later.
module tb_vga_text_renderer;
    logic pixel_clk = 1'b0;
    logic reset     = 1'b1;
    always #5 pixel_clk = ~pixel_clk;

    vga_text_renderer_if vif();

    vga_text_renderer dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .vif       (vif)
    );

    typedef struct {
        int          idx;
        logic [14:0] exp;
    } sb_t;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        bl;
        logic [11:0] rgb;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[7];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   fcnt_model = 0;
    logic prev_vs = 1'b1;

    function automatic logic [7:0] char_of(input logic [11:0] a);
        logic [7:0] r;
        r = a[7:0] ^ 8'h3C;
        if (a == 12'd162) r = 8'h41;
        return r;
    endfunction

    function automatic logic [7:0] font_of(input logic [11:0] fa);
        logic [7:0] r;
        r = fa[11:4] ^ {fa[3:0], fa[3:0]} ^ 8'hA5;
        if (fa == 12'h413) r = 8'h81;
        return r;
    endfunction

    always @(posedge pixel_clk) begin
        vif.char_data <= char_of(vif.char_addr);
        vif.font_data <= font_of(vif.font_addr);
    end

    function automatic logic [11:0] exp_rgb(input logic [11:0] x, input logic [11:0] y, input logic bl);
        int         col, row;
        logic [7:0] ch, fd;
        logic       b;
        if (!bl || x >= 12'd640 || y >= 12'd480) return 12'h000;
        col = int'(x) / 8;
        row = int'(y) / 16;
        ch  = char_of(12'(row * 80 + col));
        fd  = font_of({ch, y[3:0]});
        b   = fd[7 - (int'(x) % 8)];
`ifdef CURSOR_BLINK_EN
        if ((fcnt_model & 32) != 0 && col == int'(vif.cursor_col) && row == int'(vif.cursor_row)) b = ~b;
`endif
        return b ? 12'hFFF : 12'h000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One pixel clock: compare the output due now, then drive new inputs and queue their expectation.
    task automatic step(input logic [11:0] x, input logic [11:0] y, input logic bl,
                        input logic hs, input logic vs, input logic [11:0] rgb,
                        input bit use_model, input bit push);
        sb_t         e;
        logic [11:0] r;
        @(posedge pixel_clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].idx == cyc - 5) begin
            e = sb.pop_front();
            check("pipe", {17'd0, vif.out_hs, vif.out_vs, vif.out_blank, vif.out_r, vif.out_g, vif.out_b},
                  {17'd0, e.exp});
        end
        vif.CounterX  = x;
        vif.CounterY  = y;
        vif.vga_blank = bl;
        vif.vga_hs    = hs;
        vif.vga_vs    = vs;
        if (prev_vs && !vs) fcnt_model = (fcnt_model + 1) % 256;
        prev_vs = vs;
        r = use_model ? exp_rgb(x, y, bl) : rgb;
        if (push) begin
            e.idx = cyc;
            e.exp = {hs, vs, bl, r};
            sb.push_back(e);
        end
    endtask

    task automatic stream(input logic [11:0] x, input logic [11:0] y, input logic bl,
                          input logic hs, input logic vs);
        step(x, y, bl, hs, vs, 12'h000, 1'b1, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        sb.delete();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
        fcnt_model = 0;
        prev_vs    = 1'b1;
    endtask

    task automatic vs_edges(input int n);
        for (int i = 0; i < n; i++) begin
            stream(12'd0, 12'd0, 1'b0, 1'b1, 1'b0);
            stream(12'd0, 12'd0, 1'b0, 1'b1, 1'b1);
        end
        stream(12'd0, 12'd0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_seen, bl_seen;
        tbl[0] = '{x: 12'd16,  y: 12'd35, bl: 1'b1, rgb: 12'hFFF};
        tbl[1] = '{x: 12'd17,  y: 12'd35, bl: 1'b1, rgb: 12'h000};
        tbl[2] = '{x: 12'd23,  y: 12'd35, bl: 1'b1, rgb: 12'hFFF};
        tbl[3] = '{x: 12'd16,  y: 12'd35, bl: 1'b0, rgb: 12'h000};
        tbl[4] = '{x: 12'd640, y: 12'd10, bl: 1'b1, rgb: 12'h000};
        tbl[5] = '{x: 12'd15,  y: 12'd35, bl: 1'b1, rgb: 12'hFFF};
        tbl[6] = '{x: 12'd8,   y: 12'd480, bl: 1'b1, rgb: 12'h000};

        vif.CounterX   = '0;
        vif.CounterY   = '0;
        vif.vga_blank  = 1'b0;
        vif.vga_hs     = 1'b1;
        vif.vga_vs     = 1'b1;
        vif.cursor_col = 7'd2;
        vif.cursor_row = 5'd2;

        // Reset values
        do_reset();
        check("rst_out_hs", {31'd0, vif.out_hs}, 32'd1);
        check("rst_out_vs", {31'd0, vif.out_vs}, 32'd1);
        check("rst_out_blank", {31'd0, vif.out_blank}, 32'd0);
        check("rst_rgb", {20'd0, vif.out_r, vif.out_g, vif.out_b}, 32'd0);
        check("rst_frame_cnt", {24'd0, vif.frame_cnt}, 32'd0);
        check("rst_char_addr", {20'd0, vif.char_addr}, 32'd0);
        check("rst_font_addr", {20'd0, vif.font_addr}, 32'd0);
        reset = 1'b0;

        // Addressing: (17,35) -> cell (2,2) -> 162, then font {41,3}
        stream(12'd17, 12'd35, 1'b1, 1'b1, 1'b1);
        stream(12'd17, 12'd35, 1'b1, 1'b1, 1'b1);
        check("char_addr", {20'd0, vif.char_addr}, 32'd162);
        stream(12'd640, 12'd10, 1'b1, 1'b1, 1'b1);
        stream(12'd640, 12'd10, 1'b1, 1'b1, 1'b1);
        check("font_addr", {20'd0, vif.font_addr}, 32'h413);
        check("char_addr_hold", {20'd0, vif.char_addr}, 32'd162);

        // Table-driven pixel vectors with hand-derived expectations
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].x, tbl[i].y, tbl[i].bl, 1'b1, 1'b1, tbl[i].rgb, 1'b0, 1'b1);
        end

        // Random pixels, vsync held high so the frame counter stays put
        for (int i = 0; i < 200; i++) begin
            stream(12'($urandom_range(0, 700)), 12'($urandom_range(0, 500)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        // Latency / alignment: one scan line with hs pulse at cycle 100, blank falling at 90
        hs_seen = -1;
        bl_seen = -1;
        for (int c = 0; c < 160; c++) begin
            stream((c < 90) ? 12'(c) : 12'd0, 12'd35, c < 90, !(c >= 100 && c < 110), 1'b1);
            if (c > 0 && !vif.out_hs && hs_seen < 0) hs_seen = c;
            if (c > 5 && !vif.out_blank && bl_seen < 0) bl_seen = c;
        end
        check("hs_latency", 32'(hs_seen), 32'd105);
        check("blank_latency", 32'(bl_seen), 32'd95);
        drain();

`ifdef CURSOR_BLINK_EN
        vif.cursor_col = 7'd2;
        vif.cursor_row = 5'd2;
        do_reset();
        reset = 1'b0;
        vs_edges(32);
        step(12'd17, 12'd35, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b1);
        drain();
        do_reset();
        reset = 1'b0;
        step(12'd17, 12'd35, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1);
        drain();
        vif.cursor_col = 7'd90;
        vs_edges(32);
        step(12'd17, 12'd35, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1);
        step(12'd16, 12'd35, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b1);
        drain();
        vif.cursor_col = 7'd2;
`endif

        // Frame counter: 300 vsync falling edges wrap to 44
        do_reset();
        reset = 1'b0;
        vs_edges(300);
        check("frame_cnt", {24'd0, vif.frame_cnt}, 32'd44);
        drain();

        // Reset mid-line: outputs return to reset values on the next edge
        stream(12'd16, 12'd35, 1'b1, 1'b0, 1'b0);
        stream(12'd16, 12'd35, 1'b1, 1'b0, 1'b0);
        do_reset();
        check("midrst_blank", {31'd0, vif.out_blank}, 32'd0);
        check("midrst_hs", {31'd0, vif.out_hs}, 32'd1);
        check("midrst_frame", {24'd0, vif.frame_cnt}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) stream(12'd16, 12'd35, 1'b1, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Pixel-side consumer of the VGA timing generator: takes its hs/vs/blank and CounterX/CounterY outputs and produces 4-bit RGB for a monochrome 8x16-cell text screen.
- Uses an external char RAM and font ROM, both with a 1-cycle synchronous read.
- Delays sync and blank so they stay aligned with the RGB data driven to the DAC.
- Sits between vga_time_generator and the board VGA pins in the synthesizer display path.

Parameters:
- COLS, 80, text columns (cell width 8 px)
- ROWS, 30, text rows (cell height 16 px)
- FG_RGB, 12'hFFF, foreground colour {r,g,b} 4 bits each
- BG_RGB, 12'h000, background colour inside the text area

Ports:
- pixel_clk  in  1  pixel clock, shared with the timing generator
- reset  in  1  synchronous, active-high
- vga_hs  in  1  horizontal sync from the timing generator, active low
- vga_vs  in  1  vertical sync from the timing generator, active low
- vga_blank  in  1  1 = active video
- CounterX  in  12  active-area x, valid while vga_blank=1
- CounterY  in  12  active-area y
- char_addr  out  12  char RAM address, = row*COLS+col
- char_data  in  8  char RAM data, valid 1 cycle after char_addr
- font_addr  out  12  font ROM address {char_code[7:0], glyph_row[3:0]}
- font_data  in  8  font ROM row, bit7 = leftmost pixel, valid 1 cycle after font_addr
- cursor_col  in  7  cursor cell column (used only with the optional feature)
- cursor_row  in  5  cursor cell row (used only with the optional feature)
- out_hs  out  1  delayed vga_hs
- out_vs  out  1  delayed vga_vs
- out_blank  out  1  delayed vga_blank
- out_r  out  4  red
- out_g  out  4  green
- out_b  out  4  blue
- frame_cnt  out  8  free-running frame counter

Behaviour:
- Clocking and reset: one clock, pixel_clk; reset is synchronous and active-high.
- Reset values:
  - all pipeline registers cleared
  - out_hs=1, out_vs=1, out_blank=0
  - out_r/out_g/out_b=0
  - char_addr=0, font_addr=0, frame_cnt=0
- Pipeline: fixed latency of 5 cycles from inputs sampled at cycle t to outputs at t+5.
  - t+1: char_addr = (CounterY>>4)*COLS + (CounterX>>3), registered; the in-text flag is registered too.
  - t+2: char_data arrives from the char RAM.
  - t+3: font_addr = {char_data, CounterY[3:0] delayed 2}, registered.
  - t+4: font_data arrives from the font ROM.
  - t+5: pixel bit = font_data[7 - x3], where x3 is CounterX[2:0] delayed 4. The RGB register is loaded.
- Sideband delay: vga_hs, vga_vs and vga_blank pass through a 5-deep shift register, so out_* stays aligned with RGB.
- In-text flag: CounterX < COLS*8 and CounterY < ROWS*16, evaluated at t.
  - Outside the text area: char_addr is held at its previous value and RGB = 0.
- RGB selection at t+5:
  - delayed blank = 0 -> 0
  - else not in text -> 0
  - else bit = 1 -> FG_RGB
  - else -> BG_RGB
- Address arithmetic: row*COLS is computed in 12 bits. A 12-bit result is sufficient for COLS*ROWS <= 4096; larger values are illegal, with no wrap handling.
- frame_cnt: vga_vs is registered once in pixel_clk. The counter increments on each detected falling edge (start of the vsync pulse), wraps 255 -> 0 and is never reset except by reset.
- Reset mid-line: outputs go to reset values on the next edge. Valid RGB resumes 5 cycles after reset deasserts, with no attempt to realign mid-frame.
- Constant blank=0: RGB stays 0 and the address outputs may toggle.

Optional Feature:
- Macro: CURSOR_BLINK_EN
- Defined:
  - A cell whose (col,row) equals (cursor_col,cursor_row) has its pixel bit inverted while frame_cnt[5]=1, giving a 32-frame on / 32-frame off blink.
  - The col/row match is computed at t+1 and delayed to t+5.
  - Cursor positions outside COLS/ROWS never match.
- Undefined: cursor_col and cursor_row are ignored, no cursor logic is synthesised, and output is the pure glyph.

Test Plan:
- Reset: hold reset 3 cycles -> out_hs=1, out_vs=1, out_blank=0, RGB=0, frame_cnt=0, char_addr=0.
- Latency/alignment: drive a timing model (640x480) and pulse vga_hs low at cycle 100 -> out_hs low at cycle 105, and the out_blank edges are likewise delayed by exactly 5.
- Addressing: CounterX=17, CounterY=35, blank=1 -> char_addr = 2*80+2 = 162 one cycle later. With char_data=8'h41, font_addr = {8'h41, 4'h3} = 12'h413.
- Pixel bit: font_data=8'b1000_0001 with x3=0 -> RGB=FFF; with x3=1 -> RGB=000; with x3=7 -> RGB=FFF. The same case with blank=0 -> RGB=000.
- Text bound and frame counter: CounterX=640, CounterY=10 -> RGB=0 and char_addr unchanged. 300 vsync falling edges -> frame_cnt=44.
- CURSOR_BLINK_EN: cursor=(2,2), glyph bit 0 at (17,35):
  - frame_cnt=32 -> RGB=FFF
  - frame_cnt=0 -> RGB=000
  - cursor=(90,2) -> never inverted.
